fsqrt_seq: RTL and testbench
============================

# fsqrt_seq

Sequencer and post-processor for single-precision square root in the FPU arithmetic path. It accepts an IEEE-754 binary32 operand and a rounding mode, and resolves special operands directly. For finite positive operands it normalizes subnormals, drives the `sqrt_24` root unit through `root_start`/`root_is_exp_odd`/`root_significand`, then captures `root_sq_root` on `root_done`, rounds, and packs the result with RISC-V fflags. It sits between FPU issue (upstream) and writeback (downstream), with valid/ready on both sides.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `operand_a`  in  32  binary32 operand.
- `rm`  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 treated as RNE.
- `root_start`  out  1  one-cycle start pulse to the root unit.
- `root_is_exp_odd`  out  1  unbiased exponent is odd; held from START until the next accept.
- `root_significand`  out  24  normalized significand, bit 23 = 1; held like `root_is_exp_odd`.
- `root_done`  in  1  one-cycle pulse from the root unit; `root_sq_root` is valid in that cycle.
- `root_sq_root`  in  27  root; bit 26 = 1, bits 25:3 = fraction, bits 2:0 = guard/extra.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `result`  out  32  packed binary32.
- `fflags`  out  5  {NV, DZ, OF, UF, NX}.

## Operation
- FSM states: IDLE, START, WAIT, ROUND, OUT.
- **IDLE**
  - On `in_valid`: latch `rm` and classify `operand_a`.
  - Special operand: load `result`/`fflags` and go to OUT.
  - Otherwise: load the root operands and go to START.
- **Special cases**
  - Any NaN gives 0x7FC00000; NV=1 only for sNaN.
  - ±0 gives the same signed zero, flags 0.
  - +inf gives 0x7F800000, flags 0.
  - A negative nonzero operand (including -inf) gives 0x7FC00000 with NV=1.
- **Normalization**
  - Normal operand: significand = {1, frac}, E_eff = E.
  - Subnormal operand: lz = leading zeros of {0, frac}, in 1..23. Significand = {0, frac} << lz; E_eff = 1 − lz as a 10-bit signed value.
  - `root_is_exp_odd` = ~E_eff[0].
  - Result biased exponent Er = (E_eff + 127) >>> 1.
- **START**: `root_start`=1 for exactly one cycle, then WAIT.
- **WAIT**: hold until `root_done`=1; capture `root_sq_root` in that cycle, then ROUND.
- **ROUND** (result is always positive):
  - lsb = sq[3], g = sq[2], s = |sq[1:0], inexact = g | s.
  - Increment: RNE when g & (s | lsb); RMM when g; RUP when inexact; RTZ and RDN never.
  - Mantissa carry out of bit 23 gives mantissa 0 and Er+1.
  - Pack as {0, Er[7:0], mant[22:0]}; NX = inexact.
  - DZ, OF and UF are always 0.
  - The remainder is not visible to this block. A nonzero remainder with sq[2:0]=0 is reported exact; this is accepted for this revision.
- **OUT**
  - Hold `out_valid`, `result` and `fflags` stable until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `root_start`=0, `result`=0, `fflags`=0, `root_is_exp_odd`=0, `root_significand`=0.
- Accept in cycle 0 (`in_valid & in_ready`).
- Special path: `out_valid`=1 in cycle 1, with `root_start` never asserted.
- Normal path:
  - `root_start`=1 in cycle 1.
  - With `sqrt_24` latency, `root_done` arrives in cycle 31 and `out_valid` in cycle 33 (`root_done` + 2).
  - The block waits on `root_done` and never counts cycles.
- `root_done` outside WAIT is ignored.
- `in_ready`=0 in every state except IDLE; no accept while busy, including the cycle `out_valid & out_ready` completes.
- Reset asserted in any state returns to IDLE in the next cycle and drops `out_valid` and `root_start`. The top resets `sqrt_24` from the same source (inverted to active-low). A stale `root_done` after reset is ignored.

## Structure
- Shared `fpu_pkg`:
  - rounding-mode encodings;
  - canonical NaN 32'h7FC00000;
  - fflags bit positions;
  - FSM state encoding;
  - exponent bias 127.
- Sub-module `fsqrt_lzc24`: combinational 24-bit leading-zero counter, 5-bit output.
- `sqrt_24` is instantiated alongside this block at the FPU level, not inside it.

## Test plan
- 0x40800000 (4.0), RNE: `root_is_exp_odd`=0, `root_significand`=0x800000. Result 0x40000000, fflags 0, `out_valid` at `root_done` + 2.
- 0x40000000 (2.0): `root_is_exp_odd`=1. RNE gives 0x3FB504F3 with NX; RUP gives 0x3FB504F4 with NX; RTZ gives 0x3FB504F3.
- 0x00000001 (min subnormal), RNE: lz=23, `root_is_exp_odd`=1, `root_significand`=0x800000. Result 0x1A3504F3, NX=1.
- Specials, each with `out_valid` in cycle 1 and no `root_start`:
  - 0xBF800000 gives 0x7FC00000, NV.
  - 0x7F800001 gives 0x7FC00000, NV.
  - 0x7FC00000 gives 0x7FC00000, flags 0.
  - 0x80000000 gives 0x80000000.
  - 0x7F800000 gives 0x7F800000.
- Backpressure: `out_ready`=0 for 5 cycles. `result`/`fflags` stay stable and `in_ready`=0; a second `in_valid` is not accepted until one cycle after the handshake.
- Reset in WAIT: next cycle IDLE with `in_ready`=1 and `out_valid`=0. An injected `root_done` is ignored, and a new 4.0 operand then completes correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions for the square-root sequencer.
// Holds the rounding-mode encodings, the canonical quiet NaN, fflags bit
// positions, the exponent bias, the sequencer state encoding, and the
// increment decision used by the rounding step.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // fflags = {NV, DZ, OF, UF, NX}
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic signed [9:0] EXP_BIAS = 10'sd127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ROUND,
        ST_OUT
    } fsqrt_state_e;

    // Increment decision for a positive result. Unused encodings fall back to RNE.
    function automatic logic round_inc(input logic [2:0] mode, input logic lsb,
                                       input logic guard, input logic sticky);
        logic inc;
        case (mode)
            RM_RTZ, RM_RDN: inc = 1'b0;
            RM_RUP:         inc = guard | sticky;
            RM_RMM:         inc = guard;
            default:        inc = guard & (sticky | lsb);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fsqrt_seq_if.sv
// Upstream/downstream handshake bundle of the square-root sequencer.
//   in_valid/in_ready/operand_a/rm      : operand issue side
//   out_valid/out_ready/result/fflags   : writeback side
// master = issuer/consumer, slave = fsqrt_seq.
interface fsqrt_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  fflags;

    modport master (
        output in_valid, operand_a, rm, out_ready,
        input  in_ready, out_valid, result, fflags
    );

    modport slave (
        input  in_valid, operand_a, rm, out_ready,
        output in_ready, out_valid, result, fflags
    );
endinterface

// File: rtl/fsqrt_lzc24.sv
// Combinational 24-bit leading-zero counter.
//   value : 24-bit input
//   count : number of leading zeros, 24 when value is zero
module fsqrt_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);
    always_comb begin
        count = 5'd24;
        // Scanning upward lets the highest set bit win.
        for (int unsigned i = 0; i < 24; i++) begin
            if (value[i]) count = 5'(23 - i);
        end
    end
endmodule

// File: rtl/fsqrt_seq.sv
// Single-precision square-root sequencer and post-processor.
// Resolves special operands directly; for finite positive operands it
// normalizes the significand, drives the external root unit, then rounds
// and packs the captured root with RISC-V fflags.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   io (slave)        : in_valid/in_ready/operand_a/rm, out_valid/out_ready/result/fflags
//   root_start        : one-cycle start pulse to the root unit
//   root_is_exp_odd   : unbiased exponent is odd (held until next accept)
//   root_significand  : normalized significand, bit 23 set (held until next accept)
//   root_done         : root unit completion pulse, root_sq_root valid with it
//   root_sq_root      : {1, fraction[22:0], guard bits[2:0]}
module fsqrt_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    fsqrt_seq_if.slave  io,
    output logic        root_start,
    output logic        root_is_exp_odd,
    output logic [23:0] root_significand,
    input  logic        root_done,
    input  logic [26:0] root_sq_root
);

    fsqrt_state_e state_q, state_d;

    logic [2:0]  rm_q;
    logic [7:0]  er_q;
    logic [25:0] sq_q;
    logic [31:0] result_q;
    logic [4:0]  fflags_q;

    // ---------------- operand classification ----------------
    logic        sign;
    logic [7:0]  exp_f;
    logic [22:0] frac;
    logic        is_nan, is_snan, is_zero, is_inf, is_sub;
    logic        is_special;
    logic [31:0] spec_result;
    logic [4:0]  spec_flags;

    assign sign  = io.operand_a[31];
    assign exp_f = io.operand_a[30:23];
    assign frac  = io.operand_a[22:0];

    assign is_nan  = (exp_f == '1) && (frac != '0);
    assign is_snan = is_nan && !frac[22];
    assign is_zero = (exp_f == '0) && (frac == '0);
    assign is_inf  = (exp_f == '1) && (frac == '0);
    assign is_sub  = (exp_f == '0) && (frac != '0);

    always_comb begin
        is_special  = 1'b1;
        spec_result = CANON_NAN;
        spec_flags  = '0;
        if (is_nan) begin
            spec_flags[FLAG_NV] = is_snan;
        end else if (is_zero) begin
            spec_result = io.operand_a;
        end else if (sign) begin
            spec_flags[FLAG_NV] = 1'b1;
        end else if (is_inf) begin
            spec_result = io.operand_a;
        end else begin
            is_special = 1'b0;
        end
    end

    // ---------------- normalization ----------------
    logic [4:0]         lz;
    logic [23:0]        norm_sig;
    logic signed [9:0]  e_eff;
    logic signed [9:0]  e_sum;
    logic signed [9:0]  er_calc;

    fsqrt_lzc24 u_lzc (
        .value ({1'b0, frac}),
        .count (lz)
    );

    always_comb begin
        if (is_sub) begin
            norm_sig = {1'b0, frac} << lz;
            e_eff    = 10'sd1 - $signed({5'd0, lz});
        end else begin
            norm_sig = {1'b1, frac};
            e_eff    = $signed({2'b00, exp_f});
        end
        e_sum   = e_eff + EXP_BIAS;
        er_calc = e_sum >>> 1;
    end

    // ---------------- rounding ----------------
    logic        rnd_guard, rnd_sticky, rnd_inc;
    logic [23:0] mant_sum;
    logic [7:0]  rnd_exp;
    logic [31:0] rnd_result;
    logic [4:0]  rnd_flags;

    always_comb begin
        rnd_guard  = sq_q[2];
        rnd_sticky = |sq_q[1:0];
        rnd_inc    = round_inc(rm_q, sq_q[3], rnd_guard, rnd_sticky);
        // Carry into bit 23 leaves the fraction at zero and bumps the exponent.
        mant_sum   = {1'b0, sq_q[25:3]} + {23'd0, rnd_inc};
        rnd_exp    = er_q + {7'd0, mant_sum[23]};
        rnd_result = {1'b0, rnd_exp, mant_sum[22:0]};
        rnd_flags  = '0;
        rnd_flags[FLAG_NX] = rnd_guard | rnd_sticky;
    end

    logic unused_bits;
    assign unused_bits = ^{root_sq_root[26], er_calc[9:8]};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        root_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                io.in_ready = 1'b1;
                if (io.in_valid) state_d = is_special ? ST_OUT : ST_START;
            end
            ST_START: begin
                root_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (root_done) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                io.out_valid = 1'b1;
                if (io.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rm_q             <= '0;
            er_q             <= '0;
            sq_q             <= '0;
            result_q         <= '0;
            fflags_q         <= '0;
            root_is_exp_odd  <= 1'b0;
            root_significand <= '0;
        end else begin
            if (state_q == ST_IDLE && io.in_valid) begin
                rm_q <= io.rm;
                if (is_special) begin
                    result_q <= spec_result;
                    fflags_q <= spec_flags;
                end else begin
                    root_is_exp_odd  <= ~e_eff[0];
                    root_significand <= norm_sig;
                    er_q             <= er_calc[7:0];
                end
            end
            if (state_q == ST_WAIT && root_done) begin
                sq_q <= root_sq_root[25:0];
            end
            if (state_q == ST_ROUND) begin
                result_q <= rnd_result;
                fflags_q <= rnd_flags;
            end
        end
    end

    assign io.result = result_q;
    assign io.fflags = fflags_q;

endmodule

// File: tb/tb_fsqrt_seq.sv
// Scoreboard bench for fsqrt_seq with a behavioural root-unit stand-in that
// answers root_start with a bench-chosen root 30 cycles later.
module tb_fsqrt_seq;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        root_start, root_is_exp_odd, root_done;
    logic [23:0] root_significand;
    logic [26:0] root_sq_root;

    always #5 clk = ~clk;

    fsqrt_seq_if bus ();

    fsqrt_seq dut (
        .clk              (clk),
        .reset            (reset),
        .io               (bus),
        .root_start       (root_start),
        .root_is_exp_odd  (root_is_exp_odd),
        .root_significand (root_significand),
        .root_done        (root_done),
        .root_sq_root     (root_sq_root)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
        int          acc;
        string       name;
    } sb_t;

    typedef struct {
        logic        odd;
        logic [23:0] sig;
        logic [26:0] sq;
        int          acc;
    } rt_t;

    sb_t sb_q[$];
    rt_t rt_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on first out_valid, value compare on handshake.
    initial begin
        bit  rise;
        sb_t e;
        rise = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                rise = 1'b0;
            end else if (bus.out_valid) begin
                if (!rise) begin
                    rise = 1'b1;
                    if (sb_q.size() == 0)
                        check("unexpected_out_valid", bus.out_valid, 0);
                    else
                        check({sb_q[0].name, "_latency"}, cyc, sb_q[0].acc + sb_q[0].lat);
                end
                if (bus.out_ready) begin
                    rise = 1'b0;
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check({e.name, "_result"}, bus.result, e.res);
                        check({e.name, "_fflags"}, bus.fflags, e.flags);
                    end
                end
            end else begin
                rise = 1'b0;
            end
        end
    end

    // Root-unit stand-in.
    initial begin
        rt_t         r;
        int          done_at;
        logic [26:0] pend;
        done_at      = -1;
        pend         = '0;
        root_done    = 1'b0;
        root_sq_root = '0;
        forever begin
            @(negedge clk);
            root_done = 1'b0;
            if (!reset && root_start) begin
                if (rt_q.size() == 0) begin
                    check("unexpected_root_start", root_start, 0);
                end else begin
                    r = rt_q.pop_front();
                    check("root_start_latency", cyc, r.acc + 1);
                    check("root_is_exp_odd", root_is_exp_odd, r.odd);
                    check("root_significand", root_significand, r.sig);
                    done_at = cyc + 30;
                    pend    = r.sq;
                end
            end
            if (cyc == done_at) begin
                root_done    = 1'b1;
                root_sq_root = pend;
                done_at      = -1;
            end
        end
    end

    task automatic issue(input string name, input logic [31:0] op, input logic [2:0] mode,
                         input bit special, input logic [26:0] sq,
                         input logic [31:0] res, input logic [4:0] fl,
                         input logic odd, input logic [23:0] sig, input bit expect_out);
        int  n;
        sb_t e;
        rt_t r;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check({name, "_in_ready_timeout"}, bus.in_ready, 1);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.operand_a = op;
        bus.rm        = mode;
        last_acc      = cyc;
        if (expect_out) begin
            e.res = res; e.flags = fl; e.lat = special ? 1 : 33; e.acc = cyc; e.name = name;
            sb_q.push_back(e);
        end
        if (!special) begin
            r.odd = odd; r.sig = sig; r.sq = sq; r.acc = cyc;
            rt_q.push_back(r);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb_q.size() > 0) check("drain_timeout", sb_q.size(), 0);
    endtask

    localparam logic [26:0] SQ_ONE   = 27'h400_0000;
    localparam logic [26:0] SQ_SQRT2 = 27'h5A8_2799;
    localparam logic [26:0] SQ_CARRY = 27'h7FF_FFFC;
    localparam logic [26:0] SQ_TIE   = 27'h400_0004;

    initial begin
        sb_t e;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.operand_a = '0;
        bus.rm        = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_root_start", root_start, 0);
        check("rst_result",    bus.result, 0);
        check("rst_fflags",    bus.fflags, 0);
        check("rst_exp_odd",   root_is_exp_odd, 0);
        check("rst_sig",       root_significand, 0);

        // Normal path
        issue("four_rne",   32'h4080_0000, RM_RNE, 0, SQ_ONE,   32'h4000_0000, 5'h00, 1'b0, 24'h80_0000, 1);
        issue("two_rne",    32'h4000_0000, RM_RNE, 0, SQ_SQRT2, 32'h3FB5_04F3, 5'h01, 1'b1, 24'h80_0000, 1);
        issue("two_rup",    32'h4000_0000, RM_RUP, 0, SQ_SQRT2, 32'h3FB5_04F4, 5'h01, 1'b1, 24'h80_0000, 1);
        issue("two_rtz",    32'h4000_0000, RM_RTZ, 0, SQ_SQRT2, 32'h3FB5_04F3, 5'h01, 1'b1, 24'h80_0000, 1);
        issue("two_rdn",    32'h4000_0000, RM_RDN, 0, SQ_SQRT2, 32'h3FB5_04F3, 5'h01, 1'b1, 24'h80_0000, 1);
        issue("two_rm111",  32'h4000_0000, 3'b111, 0, SQ_SQRT2, 32'h3FB5_04F3, 5'h01, 1'b1, 24'h80_0000, 1);
        issue("min_sub",    32'h0000_0001, RM_RNE, 0, SQ_SQRT2, 32'h1A35_04F3, 5'h01, 1'b1, 24'h80_0000, 1);
        issue("sub_top",    32'h0040_0000, RM_RNE, 0, SQ_ONE,   32'h1F80_0000, 5'h00, 1'b1, 24'h80_0000, 1);
        issue("carry_rne",  32'h4080_0000, RM_RNE, 0, SQ_CARRY, 32'h4080_0000, 5'h01, 1'b0, 24'h80_0000, 1);
        issue("tie_rne",    32'h4080_0000, RM_RNE, 0, SQ_TIE,   32'h4000_0000, 5'h01, 1'b0, 24'h80_0000, 1);
        issue("tie_rmm",    32'h4080_0000, RM_RMM, 0, SQ_TIE,   32'h4000_0001, 5'h01, 1'b0, 24'h80_0000, 1);

        // Special operands
        issue("neg_one",    32'hBF80_0000, RM_RNE, 1, '0, 32'h7FC0_0000, 5'h10, 1'b0, '0, 1);
        issue("snan",       32'h7F80_0001, RM_RNE, 1, '0, 32'h7FC0_0000, 5'h10, 1'b0, '0, 1);
        issue("qnan",       32'h7FC0_0000, RM_RNE, 1, '0, 32'h7FC0_0000, 5'h00, 1'b0, '0, 1);
        issue("neg_qnan",   32'hFFC0_0000, RM_RNE, 1, '0, 32'h7FC0_0000, 5'h00, 1'b0, '0, 1);
        issue("neg_zero",   32'h8000_0000, RM_RNE, 1, '0, 32'h8000_0000, 5'h00, 1'b0, '0, 1);
        issue("pos_zero",   32'h0000_0000, RM_RNE, 1, '0, 32'h0000_0000, 5'h00, 1'b0, '0, 1);
        issue("pos_inf",    32'h7F80_0000, RM_RNE, 1, '0, 32'h7F80_0000, 5'h00, 1'b0, '0, 1);
        issue("neg_inf",    32'hFF80_0000, RM_RNE, 1, '0, 32'h7FC0_0000, 5'h10, 1'b0, '0, 1);
        drain();

        // Backpressure with a second operand waiting
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.operand_a = 32'h7F80_0000;
        bus.rm        = RM_RNE;
        e.res = 32'h7F80_0000; e.flags = 5'h00; e.lat = 1; e.acc = cyc; e.name = "bp_first";
        sb_q.push_back(e);
        @(negedge clk);
        bus.operand_a = 32'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready",  bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_result",    bus.result, 32'h7F80_0000);
            check("bp_fflags",    bus.fflags, 0);
            @(negedge clk);
        end
        check("bp_hs_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_after_in_ready",  bus.in_ready, 1);
        check("bp_after_out_valid", bus.out_valid, 0);
        e.res = 32'h8000_0000; e.flags = 5'h00; e.lat = 1; e.acc = cyc; e.name = "bp_second";
        sb_q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        drain();

        // Reset while waiting on the root unit; its late root_done must be ignored
        issue("rst_wait", 32'h4080_0000, RM_RNE, 0, SQ_ONE, '0, '0, 1'b0, 24'h80_0000, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstw_in_ready",   bus.in_ready, 1);
        check("rstw_out_valid",  bus.out_valid, 0);
        check("rstw_root_start", root_start, 0);
        while (cyc < last_acc + 35) begin
            @(negedge clk);
            check("rstw_idle_in_ready",  bus.in_ready, 1);
            check("rstw_idle_out_valid", bus.out_valid, 0);
        end
        issue("four_after_rst", 32'h4080_0000, RM_RNE, 0, SQ_ONE, 32'h4000_0000, 5'h00, 1'b0, 24'h80_0000, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
